// File: rtl/ram_port_arbiter.sv
// N-channel arbiter sharing one synchronous RAM port between several masters.
// Round-robin or fixed-priority grant, registered issue stage, tagged read return.
module ram_port_arbiter #(
  parameter int NCH       = 4,
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     mem_address,
  output logic [DW-1:0]     mem_data,
  output logic              mem_wren,
  input  logic [DW-1:0]     mem_q
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

  // Index wrap uses an explicit compare so non-power-of-two NCH stays in range.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NCH) begin
      sum = sum - NCH;
    end else begin
      sum = sum;
    end
    return PW'(sum);
  endfunction

  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   idx_s;
  logic [PW-1:0]   win_s;
  logic            found_s;
  logic [NCH-1:0]  gnt_s;
  logic            win_we_s;
  logic [AW-1:0]   win_addr_s;
  logic [DW-1:0]   win_wdata_s;

  logic [AW-1:0]   mem_address_r;
  logic [DW-1:0]   mem_data_r;
  logic            mem_wren_r;
  logic            rd_issue_r;
  logic [PW-1:0]   tag_issue_r;
  logic [RD_LAT:0] pv_r;
  logic [PW-1:0]   pt_r [0:RD_LAT];

  // Winner search: scan from ptr (round-robin) or from channel 0 (fixed priority).
  always_comb begin
    idx_s   = '0;
    win_s   = '0;
    found_s = 1'b0;
    for (int off = 0; off < NCH; off++) begin
      idx_s   = (PRIO_MODE == 1) ? PW'(off) : wrap_add(ptr_r, off);
      win_s   = (!found_s && req[idx_s]) ? idx_s : win_s;
      found_s = found_s | req[idx_s];
    end
    gnt_s = (found_s && reset_n) ? (ONE_HOT0 << win_s) : '0;
  end

  assign win_we_s    = we[win_s];
  assign win_addr_s  = addr[win_s*AW +: AW];
  assign win_wdata_s = wdata[win_s*DW +: DW];

  // Round-robin pointer advances past the channel just served.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_r <= '0;
    end else if (found_s && (PRIO_MODE == 0)) begin
      ptr_r <= wrap_add(win_s, 1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Issue stage: address/data hold between transfers, write enable is a one-cycle pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_address_r <= '0;
      mem_data_r    <= '0;
      mem_wren_r    <= 1'b0;
      rd_issue_r    <= 1'b0;
      tag_issue_r   <= '0;
    end else if (found_s) begin
      mem_address_r <= win_addr_s;
      mem_data_r    <= win_wdata_s;
      mem_wren_r    <= win_we_s;
      rd_issue_r    <= ~win_we_s;
      tag_issue_r   <= win_s;
    end else begin
      mem_address_r <= mem_address_r;
      mem_data_r    <= mem_data_r;
      mem_wren_r    <= 1'b0;
      rd_issue_r    <= 1'b0;
      tag_issue_r   <= tag_issue_r;
    end
  end

  // Read tag pipeline, RD_LAT+1 deep, aligned with the RAM's q output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pv_r <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pt_r[i] <= '0;
      end
    end else begin
      pv_r    <= {pv_r[RD_LAT-1:0], rd_issue_r};
      pt_r[0] <= tag_issue_r;
      for (int i = 1; i <= RD_LAT; i++) begin
        pt_r[i] <= pt_r[i-1];
      end
    end
  end

  assign gnt         = gnt_s;
  assign rvalid      = pv_r[RD_LAT] ? (ONE_HOT0 << pt_r[RD_LAT]) : '0;
  assign rdata       = mem_q;
  assign mem_address = mem_address_r;
  assign mem_data    = mem_data_r;
  assign mem_wren    = mem_wren_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: three instances (RR lat1, fixed lat1, RR lat2)
// driven with shared inputs, each with its own behavioural synchronous RAM.
module tb_ram_port_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int ND  = 3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    req = 4'b1111;
  logic [NCH-1:0]    we = 4'b0000;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH*DW-1:0] wdata = '0;

  logic [NCH-1:0] gnt_a [ND];
  logic [NCH-1:0] rvalid_a [ND];
  logic [DW-1:0]  rdata_a [ND];
  logic [AW-1:0]  mem_address_a [ND];
  logic [DW-1:0]  mem_data_a [ND];
  logic           mem_wren_a [ND];
  logic [DW-1:0]  mem_q_a [ND];

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : g_dut
      localparam int LAT = (g == 2) ? 2 : 1;
      localparam int PM  = (g == 1) ? 1 : 0;
      logic [DW-1:0] mem [0:255];
      logic [AW-1:0] a_r;
      logic [DW-1:0] d1_r;
      logic [DW-1:0] d2_r;

      ram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(LAT), .PRIO_MODE(PM)) u_dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_a[g]), .rvalid(rvalid_a[g]), .rdata(rdata_a[g]),
        .mem_address(mem_address_a[g]), .mem_data(mem_data_a[g]),
        .mem_wren(mem_wren_a[g]), .mem_q(mem_q_a[g])
      );

      // RAM samples the address, then q appears LAT cycles later.
      always @(posedge clock) begin
        if (mem_wren_a[g]) mem[mem_address_a[g][7:0]] <= mem_data_a[g];
        a_r  <= mem_address_a[g];
        d1_r <= mem[a_r[7:0]];
        d2_r <= d1_r;
      end
      assign mem_q_a[g] = (LAT == 2) ? d2_r : d1_r;
    end
  endgenerate

  typedef struct {
    logic [3:0] req;
    logic [3:0] g_rr;
    logic [3:0] g_fp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic set_ch(input int ch, input logic [15:0] a, input logic [15:0] wd);
    addr[ch*AW +: AW]  = a;
    wdata[ch*DW +: DW] = wd;
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s gnt d%0d", tag, d), 32'(gnt_a[d]), 32'h0);
      chk($sformatf("%s wren d%0d", tag, d), 32'(mem_wren_a[d]), 32'h0);
      chk($sformatf("%s addr d%0d", tag, d), 32'(mem_address_a[d]), 32'h0);
      chk($sformatf("%s rvalid d%0d", tag, d), 32'(rvalid_a[d]), 32'h0);
    end
  endtask

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0100, 4'b0001};
    tbl[3]  = '{4'b1111, 4'b1000, 4'b0001};
    tbl[4]  = '{4'b1111, 4'b0001, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010, 4'b0001};
    tbl[6]  = '{4'b1111, 4'b0100, 4'b0001};
    tbl[7]  = '{4'b1111, 4'b1000, 4'b0001};
    tbl[8]  = '{4'b1010, 4'b0010, 4'b0010};
    tbl[9]  = '{4'b1010, 4'b1000, 4'b0010};
    tbl[10] = '{4'b1010, 4'b0010, 4'b0010};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0100, 4'b0100, 4'b0100};
    tbl[13] = '{4'b1001, 4'b1000, 4'b0001};
    tbl[14] = '{4'b1001, 4'b0001, 4'b0001};
    tbl[15] = '{4'b0001, 4'b0001, 4'b0001};

    // Reset held with all channels requesting.
    repeat (2) @(negedge clock);
    #1;
    chk_idle_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    req = 4'b0000;
    @(negedge clock);
    chk_idle_outputs("post-reset idle");

    // Grant vectors; all reads at address 0.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      req = tbl[i].req;
      we  = 4'b0000;
      #1;
      chk($sformatf("gnt rr v%0d", i), 32'(gnt_a[0]), 32'(tbl[i].g_rr));
      chk($sformatf("gnt fp v%0d", i), 32'(gnt_a[1]), 32'(tbl[i].g_fp));
      chk($sformatf("gnt rr2 v%0d", i), 32'(gnt_a[2]), 32'(tbl[i].g_rr));
    end
    @(negedge clock);
    req = 4'b0000;
    repeat (6) @(negedge clock);

    // ch2 writes BEEF to 0x0040, then ch0 reads it back.
    req = 4'b0100; we = 4'b0100;
    set_ch(2, 16'h0040, 16'hBEEF);
    #1;
    for (int d = 0; d < ND; d++) chk($sformatf("wr gnt d%0d", d), 32'(gnt_a[d]), 32'h4);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clock);
      if (j == 0) begin
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("wr wren d%0d", d), 32'(mem_wren_a[d]), 32'h1);
          chk($sformatf("wr addr d%0d", d), 32'(mem_address_a[d]), 32'h0040);
          chk($sformatf("wr data d%0d", d), 32'(mem_data_a[d]), 32'hBEEF);
        end
        req = 4'b0001; we = 4'b0000;
        set_ch(0, 16'h0040, 16'h0000);
      end else begin
        if (j == 1) begin
          for (int d = 0; d < ND; d++) begin
            chk($sformatf("wr pulse end d%0d", d), 32'(mem_wren_a[d]), 32'h0);
            chk($sformatf("rd addr d%0d", d), 32'(mem_address_a[d]), 32'h0040);
          end
          req = 4'b0000;
        end
        for (int d = 0; d < ND; d++) begin
          chk($sformatf("wr-rd rvalid d%0d j%0d", d, j), 32'(rvalid_a[d]),
              (j == lat_of(d) + 2) ? 32'h1 : 32'h0);
          if (j == lat_of(d) + 2)
            chk($sformatf("wr-rd rdata d%0d", d), 32'(rdata_a[d]), 32'hBEEF);
        end
      end
    end

    // Preload 0x0010/0x0011 through ch0, then ch1 and ch3 read back-to-back.
    @(negedge clock);
    req = 4'b0001; we = 4'b0001;
    set_ch(0, 16'h0010, 16'h1111);
    @(negedge clock);
    set_ch(0, 16'h0011, 16'h2222);
    @(negedge clock);
    req = 4'b0010; we = 4'b0000;
    set_ch(1, 16'h0010, 16'h0000);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clock);
      if (j == 0) begin
        req = 4'b1000;
        set_ch(3, 16'h0011, 16'h0000);
      end else if (j == 1) begin
        req = 4'b0000;
      end
      for (int d = 0; d < ND; d++) begin
        logic [31:0] exp_rv;
        exp_rv = (j == lat_of(d) + 1) ? 32'h2 : (j == lat_of(d) + 2) ? 32'h8 : 32'h0;
        chk($sformatf("pipe rvalid d%0d j%0d", d, j), 32'(rvalid_a[d]), exp_rv);
        if (exp_rv == 32'h2) chk($sformatf("pipe rdata1 d%0d", d), 32'(rdata_a[d]), 32'h1111);
        if (exp_rv == 32'h8) chk($sformatf("pipe rdata2 d%0d", d), 32'(rdata_a[d]), 32'h2222);
      end
    end

    // Reset one cycle after accepting a ch2 read; the read must never return.
    @(negedge clock);
    req = 4'b0100; we = 4'b0000;
    set_ch(2, 16'h0040, 16'h0000);
    @(negedge clock);
    req = 4'b0000;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_idle_outputs($sformatf("mid reset k%0d", k));
      @(negedge clock);
    end
    reset_n = 1'b1;
    req = 4'b1111;
    #1;
    for (int d = 0; d < ND; d++) chk($sformatf("first gnt d%0d", d), 32'(gnt_a[d]), 32'h1);
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      for (int d = 0; d < ND; d++)
        chk($sformatf("flushed rvalid d%0d k%0d", d, k), 32'(rvalid_a[d]), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
